// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - MIPS memory stage: data-memory handshake, branch/jump resolve, MEM/WB latch
// Optional: MEM_ALIGN_CHECK_EN traps misaligned accesses and adds the sticky align_fault output.
module memory_stage (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ex_dREN,
  input  logic        ex_dWEN,
  input  logic        ex_BEQ,
  input  logic        ex_BNE,
  input  logic        ex_zero,
  input  logic [1:0]  ex_JumpSel,
  input  logic [31:0] ex_JumpAddr,
  input  logic [31:0] ex_NPC,
  input  logic [31:0] ex_Imm_Ext,
  input  logic [31:0] ex_port_a,
  input  logic [31:0] ex_port_b,
  input  logic [31:0] ex_port_o,
  input  logic [4:0]  ex_Rw,
  input  logic        ex_RegWEN,
  input  logic        ex_MemtoReg,
  input  logic        ex_halt,
  input  logic        advance,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        mem_stall,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic [4:0]  wb_Rw,
  output logic        wb_RegWEN,
  output logic        wb_halt,
  output logic [31:0] wb_wdata,
  output logic [31:0] FW_mem_data
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        align_fault
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state;
  logic        access;
  logic        misaligned;
  logic        req;
  logic        hit;
  logic        stall;
  logic        latch_en;
  logic        taken;
  logic        jump_abs;
  logic        jump_reg;
  logic [31:0] load_buf;
  logic [31:0] load_data;
  logic [31:0] sel_wdata;

  assign access = ex_dREN | ex_dWEN;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = access & (ex_port_o[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Request is live until the instruction's dhit has been seen (DONE).
  assign req      = access & ~misaligned & (state != DONE);
  assign hit      = req & dhit;
  assign stall    = req & ~dhit;
  assign latch_en = advance & ~stall;

  // Strobes are gated by reset so a reset mid-access drops them at once.
  assign dmemREN   = nRST & req & ex_dREN;
  assign dmemWEN   = nRST & req & ex_dWEN;
  assign dmemaddr  = ex_port_o;
  assign dmemstore = ex_port_b;
  assign mem_stall = stall;

  assign taken       = (ex_BEQ & ex_zero) | (ex_BNE & ~ex_zero);
  assign jump_abs    = (ex_JumpSel == 2'd1);
  assign jump_reg    = (ex_JumpSel == 2'd2);
  assign pc_redirect = taken | jump_abs | jump_reg;

  always_comb begin
    pc_target = ex_NPC + (ex_Imm_Ext << 2);
    if (jump_abs)
      pc_target = ex_JumpAddr;
    else if (jump_reg)
      pc_target = ex_port_a;
  end

  assign load_data = hit ? dmemload : load_buf;

  always_comb begin
    sel_wdata = ex_port_o;
    if (ex_MemtoReg)
      sel_wdata = load_data;
    else if (jump_abs & ex_RegWEN)
      sel_wdata = ex_NPC;
  end

  // A hit that retires in the same cycle returns straight to IDLE so the
  // next instruction sees a fresh request slot.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (access & ~misaligned) begin
            if (dhit)
              state <= advance ? IDLE : DONE;
            else
              state <= WAIT;
          end
        end
        WAIT: begin
          if (dhit)
            state <= advance ? IDLE : DONE;
        end
        DONE: begin
          if (advance)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      load_buf <= 32'd0;
    else if (hit & ex_dREN)
      load_buf <= dmemload;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wb_Rw     <= 5'd0;
      wb_RegWEN <= 1'b0;
      wb_halt   <= 1'b0;
      wb_wdata  <= 32'd0;
    end else if (latch_en) begin
      wb_Rw     <= ex_Rw;
      wb_RegWEN <= ex_RegWEN & ~misaligned;
      wb_halt   <= ex_halt | misaligned;
      wb_wdata  <= sel_wdata;
    end else if (stall) begin
      wb_Rw     <= 5'd0;
      wb_RegWEN <= 1'b0;
      wb_halt   <= 1'b0;
      wb_wdata  <= 32'd0;
    end
  end

  assign FW_mem_data = wb_wdata;

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      align_fault <= 1'b0;
    else if (latch_en & misaligned)
      align_fault <= 1'b1;
  end
`endif

endmodule
